// File: rtl/bcd_serial_add_ctrl_if.sv
// Operand/result bundle between the operand capture logic and the serial BCD adder.
// The master side drives the operands and start; the slave side is the adder.
interface bcd_serial_add_ctrl_if #(
  parameter int NDIG = 4
);
  logic              start;
  logic              cin;
  logic [4*NDIG-1:0] A;
  logic [4*NDIG-1:0] B;
  logic [4*NDIG-1:0] SUM;
  logic              COUT;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, cin, A, B,
    input  SUM, COUT, busy, done, err
  );

  modport slave (
    input  start, cin, A, B,
    output SUM, COUT, busy, done, err
  );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one shared single-digit BCD stage, LSD first,
// running carry held in a register, start/busy/done handshake.
module bcd_serial_add_ctrl #(
  parameter int NDIG = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  bcd_serial_add_ctrl_if.slave bus
);

  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_e;
  typedef logic [NDIG-1:0][3:0] digits_t;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          carry_q, carry_d;
  digits_t       a_q, a_d;
  digits_t       b_q, b_d;
  digits_t       sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [3:0] a_dig, b_dig, dig;
  logic [4:0] s, s_adj;
  logic       dig_carry;

  // Shared single-digit stage: binary sum, then +6 correction above 9.
  always_comb begin
    a_dig     = a_q[count_q];
    b_dig     = b_q[count_q];
    s         = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0, carry_q};
    s_adj     = s + 5'd6;
    dig_carry = (s > 5'd9);
    dig       = dig_carry ? s_adj[3:0] : s[3:0];
  end

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the case leaves one unassigned and no latch is inferred.
    state_d = state_q;
    count_d = count_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          carry_d = bus.cin;
          sum_d   = '0;
          cout_d  = 1'b0;
          err_d   = 1'b0;
          count_d = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        sum_d[count_q] = dig;
        carry_d        = dig_carry;
        err_d          = err_q | (a_dig > 4'd9) | (b_dig > 4'd9);
        if (count_q == LAST) begin
          cout_d  = dig_carry;
          state_d = S_DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Handshake outputs are registered, derived from the next state.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values; blocking ones would create order-dependent races.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.SUM  = sum_q;
  assign bus.COUT = cout_q;
  assign bus.err  = err_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl: expected results are queued at launch
// and compared when done pulses.
module tb_bcd_serial_add_ctrl;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
  } res_t;

  logic Clock = 1'b0;
  logic Reset;

  bcd_serial_add_ctrl_if #(.NDIG(NDIG)) bus ();

  bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  res_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Drives operands with start for one edge (edge E0), then drops start.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bus.A     = a;
    bus.B     = b;
    bus.cin   = c;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] r = '0;
    int           v = n;
    for (int k = 0; k < NDIG; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({bus.busy, bus.done, bus.COUT, bus.err} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: busy/done/cout/err got %b expected 0000",
               {bus.busy, bus.done, bus.COUT, bus.err});
    end
    tests_run++;
    if (bus.SUM !== '0) begin
      tests_failed++;
      $display("FAIL reset_sum: got %h expected 0000", bus.SUM);
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    res_t e, got;
    sb.push_back('{sum: 16'h6912, cout: 1'b0, err: 1'b0});
    launch(16'h1234, 16'h5678, 1'b0);
    bus.A   = 16'hFFFF;
    bus.B   = 16'hFFFF;
    bus.cin = 1'b1;
    tests_run++;
    if (bus.busy !== 1'b1 || bus.SUM !== 16'h0000) begin
      tests_failed++;
      $display("FAIL basic_e0: busy=%b sum=%h expected busy=1 sum=0000", bus.busy, bus.SUM);
    end
    tick();
    tests_run++;
    if (bus.SUM !== 16'h0002 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_partial: sum=%h done=%b expected sum=0002 done=0", bus.SUM, bus.done);
    end
    tick();
    tick();
    tests_run++;
    if (bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_early_done: got done=%b expected 0", bus.done);
    end
    tick();
    tests_run++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_latency: done=%b busy=%b expected 1 1", bus.done, bus.busy);
    end
    e   = sb.pop_front();
    got = '{sum: bus.SUM, cout: bus.COUT, err: bus.err};
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL basic_result: got %h expected %h", got, e);
    end
    tick();
    tests_run++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.SUM !== 16'h6912) begin
      tests_failed++;
      $display("FAIL basic_idle_hold: done=%b busy=%b sum=%h expected 0 0 6912",
               bus.done, bus.busy, bus.SUM);
    end
  endtask

  // Fixed carry cases from the plan plus a few random decimal operands.
  task automatic test_carry_and_random();
    logic [W-1:0] av[6];
    logic [W-1:0] bv[6];
    logic         cv[6];
    res_t         e, got;
    bit           ok;
    av[0] = 16'h9999; bv[0] = 16'h0001; cv[0] = 1'b0;
    av[1] = 16'h0999; bv[1] = 16'h0000; cv[1] = 1'b1;
    sb.push_back('{sum: 16'h0000, cout: 1'b1, err: 1'b0});
    sb.push_back('{sum: 16'h1000, cout: 1'b0, err: 1'b0});
    for (int i = 2; i < 6; i++) begin
      int ai = int'($urandom_range(0, 9999));
      int bi = int'($urandom_range(0, 9999));
      int t;
      cv[i] = 1'($urandom_range(0, 1));
      av[i] = int2bcd(ai);
      bv[i] = int2bcd(bi);
      t     = ai + bi + int'(cv[i]);
      sb.push_back('{sum: int2bcd(t % 10000), cout: (t >= 10000), err: 1'b0});
    end
    for (int i = 0; i < 6; i++) begin
      launch(av[i], bv[i], cv[i]);
      wait_done(ok);
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL carry_timeout[%0d]: done=%b expected 1 within 20 cycles", i, bus.done);
        void'(sb.pop_front());
      end else begin
        e   = sb.pop_front();
        got = '{sum: bus.SUM, cout: bus.COUT, err: bus.err};
        if (got !== e) begin
          tests_failed++;
          $display("FAIL carry_result[%0d] A=%h B=%h cin=%b: got %h expected %h",
                   i, av[i], bv[i], cv[i], got, e);
        end
      end
      tick();
    end
  endtask

  task automatic test_invalid();
    res_t e, got;
    bit   ok;
    sb.push_back('{sum: 16'h0105, cout: 1'b0, err: 1'b1});
    sb.push_back('{sum: 16'h0005, cout: 1'b0, err: 1'b0});
    for (int i = 0; i < 2; i++) begin
      if (i == 0) launch(16'h00A0, 16'h0005, 1'b0);
      else        launch(16'h0002, 16'h0003, 1'b0);
      wait_done(ok);
      e = sb.pop_front();
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL invalid_timeout[%0d]: done=%b expected 1", i, bus.done);
      end else begin
        got = '{sum: bus.SUM, cout: bus.COUT, err: bus.err};
        if (got !== e) begin
          tests_failed++;
          $display("FAIL invalid_result[%0d]: got %h expected %h", i, got, e);
        end
      end
      tick();
    end
  endtask

  task automatic test_ignore_start();
    res_t e, got;
    int   ndone = 0;
    sb.push_back('{sum: 16'h5555, cout: 1'b0, err: 1'b0});
    launch(16'h1234, 16'h4321, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      if (c == 2 || c == 5) begin
        bus.start = 1'b1;
        bus.A     = 16'h9999;
        bus.B     = 16'h8888;
        bus.cin   = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      if (bus.done === 1'b1) begin
        ndone++;
        e   = sb.pop_front();
        got = '{sum: bus.SUM, cout: bus.COUT, err: bus.err};
        tests_run++;
        if (got !== e || c != 4) begin
          tests_failed++;
          $display("FAIL ignore_result: got %h at cycle %0d expected %h at cycle 4", got, c, e);
        end
      end
    end
    tests_run++;
    if (ndone != 1 || bus.busy !== 1'b0 || bus.SUM !== 16'h5555) begin
      tests_failed++;
      $display("FAIL ignore_pulses: done_count=%0d busy=%b sum=%h expected 1 0 5555",
               ndone, bus.busy, bus.SUM);
    end
  endtask

  task automatic test_mid_reset();
    res_t e, got;
    bit   ok;
    launch(16'h1234, 16'h1111, 1'b0);
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tests_run++;
    if ({bus.busy, bus.done, bus.COUT} !== 3'b000 || bus.SUM !== '0) begin
      tests_failed++;
      $display("FAIL midreset_state: busy/done/cout=%b sum=%h expected 000 0000",
               {bus.busy, bus.done, bus.COUT}, bus.SUM);
    end
    tick();
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_stays_idle: busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    sb.push_back('{sum: 16'h2345, cout: 1'b0, err: 1'b0});
    launch(16'h1234, 16'h1111, 1'b0);
    wait_done(ok);
    e = sb.pop_front();
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL midreset_timeout: done=%b expected 1", bus.done);
    end else begin
      got = '{sum: bus.SUM, cout: bus.COUT, err: bus.err};
      if (got !== e) begin
        tests_failed++;
        $display("FAIL midreset_result: got %h expected %h", got, e);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    res_t e, got;
    int   ndone    = 0;
    int   last     = 0;
    int   idle_cnt = 0;
    for (int i = 0; i < 3; i++) sb.push_back('{sum: 16'h0000, cout: 1'b1, err: 1'b0});
    bus.A     = 16'h4999;
    bus.B     = 16'h5001;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= 40 && ndone < 3; cyc++) begin
      tick();
      if (bus.busy === 1'b0) idle_cnt++;
      if (bus.done === 1'b1) begin
        ndone++;
        e   = sb.pop_front();
        got = '{sum: bus.SUM, cout: bus.COUT, err: bus.err};
        tests_run++;
        if (got !== e) begin
          tests_failed++;
          $display("FAIL b2b_result[%0d]: got %h expected %h", ndone, got, e);
        end
        tests_run++;
        if (ndone == 1 ? (cyc != NDIG + 1) : (cyc - last != NDIG + 2)) begin
          tests_failed++;
          $display("FAIL b2b_period[%0d]: done at cycle %0d (previous %0d) expected spacing %0d",
                   ndone, cyc, last, NDIG + 2);
        end
        tests_run++;
        if (idle_cnt != (ndone == 1 ? 0 : 1)) begin
          tests_failed++;
          $display("FAIL b2b_idle_gap[%0d]: busy-low cycles=%0d expected %0d",
                   ndone, idle_cnt, (ndone == 1 ? 0 : 1));
        end
        last     = cyc;
        idle_cnt = 0;
        if (ndone == 3) bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    tests_run++;
    if (ndone != 3) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d done pulses expected 3", ndone);
    end
    tick();
    tick();
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_final_idle: busy=%b expected 0", bus.busy);
    end
  endtask

  initial begin
    Reset     = 1'b1;
    bus.start = 1'b0;
    bus.cin   = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    test_reset();
    test_basic();
    test_carry_and_random();
    test_invalid();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
